// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : RV32I byte/half/word load-store sequencer with
// read-modify-write for sub-word stores. Optional LSU_MISALIGN_TRAP_EN.
// Revision: 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam logic [31:0] C_TIMEOUT = 32'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_wword;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_cnt;

  logic              w_accept;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_timeout;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_illegal = req_store ? (req_funct3 > 3'd2)
                               : ((req_funct3 == 3'd3) || (req_funct3 >= 3'd6));
  assign w_timeout = (C_TIMEOUT != 32'd0) && ((r_cnt + 32'd1) == C_TIMEOUT);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
`else
  assign w_misalign = 1'b0;
`endif

  // Lane selection from the captured address; bit 0 is ignored for halves.
  assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load = mem_rdata;
    case (r_funct3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd4:    w_load = {24'd0, w_byte};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = mem_rdata;
    if (r_funct3[1:0] == 2'd0)
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_illegal || w_misalign)      w_next = S_RSP;
          else if (!req_store)              w_next = S_RD;
          else if (req_funct3 == 3'd2)      w_next = S_WR;
          else                              w_next = S_RD;
        end
      end
      S_RD: begin
        mem_req  = 1'b1;
        mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
        if (mem_ready)      w_next = r_store ? S_WR : S_RSP;
        else if (w_timeout) w_next = S_RSP;
      end
      S_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = r_wword;
        if (mem_ready || w_timeout) w_next = S_RSP;
      end
      default: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
        w_next    = S_IDLE;
      end
    endcase
  end

  // Completion by mem_ready takes priority over an expiring timeout.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_wword  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
      r_cnt    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_wword  <= req_wdata;
            r_rdata  <= 32'd0;
            r_err    <= w_illegal || w_misalign;
            r_cnt    <= 32'd0;
          end
        end
        S_RD: begin
          if (mem_ready) begin
            if (!r_store) r_rdata <= w_load;
            else          r_wword <= w_merge;
            r_cnt <= 32'd0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_WR: begin
          if (!mem_ready) begin
            if (w_timeout) r_err <= 1'b1;
            else           r_cnt <= r_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
